// File: rtl/qrd_pkg.sv
// Shared definitions for the QRD row-skewing transmitter: matrix geometry,
// sample format, FSM state encoding and the complex sample type.
package qrd_pkg;

  localparam int IN_WIDTH  = 14;
  localparam int H_SIZE    = 4;
  localparam int ONE_VAL   = 1024;
  localparam int NBEATS    = 16;
  localparam int FRAC_BITS = 10;
  localparam int N_ELEM    = H_SIZE * H_SIZE;

  typedef enum logic {
    LOAD = 1'b0,
    SEND = 1'b1
  } state_e;

  typedef struct packed {
    logic signed [IN_WIDTH-1:0] r;
    logic signed [IN_WIDTH-1:0] i;
  } cplx_t;

  // Identity diagonal value as it appears on the output bus (truncated to the sample width)
  localparam logic signed [IN_WIDTH-1:0] ONE_Q = IN_WIDTH'(ONE_VAL);

  // Row-major element index of H[row][col]
  function automatic logic [3:0] elem_addr(input int row, input int col);
    return 4'(row * H_SIZE + col);
  endfunction

endpackage

// File: rtl/qrd_row_skewer_if.sv
// Bus bundle between the matrix source / QRD core and the row skewer:
// element input stream, QRD beat handshake and the four skewed row outputs.
interface qrd_row_skewer_if;
  import qrd_pkg::*;

  logic                       s_valid;
  logic                       s_ready;
  logic signed [IN_WIDTH-1:0] s_data_r;
  logic signed [IN_WIDTH-1:0] s_data_i;
  logic                       in_ready;
  logic signed [IN_WIDTH-1:0] row_in_1_r;
  logic signed [IN_WIDTH-1:0] row_in_1_i;
  logic signed [IN_WIDTH-1:0] row_in_2_r;
  logic signed [IN_WIDTH-1:0] row_in_2_i;
  logic signed [IN_WIDTH-1:0] row_in_3_r;
  logic signed [IN_WIDTH-1:0] row_in_3_i;
  logic signed [IN_WIDTH-1:0] row_in_4_r;
  logic signed [IN_WIDTH-1:0] row_in_4_i;
  logic                       row_in_1_f;
  logic                       row_in_2_f;
  logic                       row_in_3_f;
  logic                       busy;

  // Environment side: element source and QRD core
  modport master (
    output s_valid, s_data_r, s_data_i, in_ready,
    input  s_ready,
    input  row_in_1_r, row_in_1_i, row_in_2_r, row_in_2_i,
    input  row_in_3_r, row_in_3_i, row_in_4_r, row_in_4_i,
    input  row_in_1_f, row_in_2_f, row_in_3_f, busy
  );

  // Row skewer side
  modport slave (
    input  s_valid, s_data_r, s_data_i, in_ready,
    output s_ready,
    output row_in_1_r, row_in_1_i, row_in_2_r, row_in_2_i,
    output row_in_3_r, row_in_3_i, row_in_4_r, row_in_4_i,
    output row_in_1_f, row_in_2_f, row_in_3_f, busy
  );

endinterface

// File: rtl/qrd_mat_buf.sv
// 16-entry complex register file holding one 4x4 matrix: one write port
// addressed by row-major element index, four combinational read ports
// (one per output row).
module qrd_mat_buf
  import qrd_pkg::*;
(
  input  logic                       clk,
  input  logic                       we,
  input  logic [3:0]                 waddr,
  input  cplx_t                      wdata,
  input  logic [H_SIZE-1:0][3:0]     raddr,
  output cplx_t [H_SIZE-1:0]         rdata
);

  cplx_t mem [N_ELEM];

  // Element storage; contents are don't-care after reset so no reset is applied
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Independent read port per output row
  always_comb begin
    rdata = '0;
    for (int k = 0; k < H_SIZE; k++) rdata[k] = mem[raddr[k]];
  end

endmodule

// File: rtl/qrd_row_skewer.sv
// QRD row-input skewer: collects a 4x4 complex matrix H from a row-major
// element stream, then emits [H | I] as four time-skewed row streams (row k
// delayed by k beats) with start flags, advancing on the QRD's in_ready.
// Optional feature macro PINGPONG_EN: two buffer banks so the next matrix
// can be loaded while the current one is being emitted.
module qrd_row_skewer
  import qrd_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  qrd_row_skewer_if.slave  bus
);

  if (H_SIZE != 4) begin : g_size_check
    $error("qrd_row_skewer supports only H_SIZE == 4");
  end

  localparam logic [4:0] LAST_BEAT = 5'(NBEATS - 1);
  localparam logic [4:0] END_BEAT  = 5'(NBEATS);

  state_e                   state;
  logic [3:0]               cnt;
  logic [4:0]               beat;
  logic                     busy_q;
  cplx_t [H_SIZE-1:0]       row_q;
  cplx_t [H_SIZE-1:0]       row_nxt;
  cplx_t [H_SIZE-1:0]       rd_data;
  logic [2:0]               flag_q;
  logic [2:0]               flag_nxt;
  logic [H_SIZE-1:0][3:0]   raddr;
  logic signed [5:0]        col [H_SIZE];
  logic                     accept;
  logic                     fill_done;
  cplx_t                    wdata;

  assign wdata.r   = bus.s_data_r;
  assign wdata.i   = bus.s_data_i;
  assign accept    = bus.s_valid & bus.s_ready;
  assign fill_done = accept & (cnt == 4'(N_ELEM - 1));

`ifdef PINGPONG_EN
  logic [1:0]          full;
  logic                wr_bank;
  logic                rd_bank;
  logic                other_full;
  cplx_t [H_SIZE-1:0]  rd_data0;
  cplx_t [H_SIZE-1:0]  rd_data1;

  qrd_mat_buf u_buf0 (
    .clk   (clk),
    .we    (accept & ~wr_bank),
    .waddr (cnt),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rd_data0)
  );

  qrd_mat_buf u_buf1 (
    .clk   (clk),
    .we    (accept & wr_bank),
    .waddr (cnt),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rd_data1)
  );

  assign rd_data     = rd_bank ? rd_data1 : rd_data0;
  assign bus.s_ready = ~full[wr_bank];
  // The idle bank counts as ready even when its last element lands on this very edge
  assign other_full  = full[~rd_bank] | (fill_done & (wr_bank != rd_bank));
`else
  qrd_mat_buf u_buf (
    .clk   (clk),
    .we    (accept),
    .waddr (cnt),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rd_data)
  );

  assign bus.s_ready = (state == LOAD);
`endif

  // Column of the augmented matrix each row shows on the current beat, and its buffer address
  always_comb begin
    raddr = '0;
    for (int k = 0; k < H_SIZE; k++) begin
      col[k]   = $signed({1'b0, beat}) - $signed(6'(k));
      raddr[k] = elem_addr(k, int'(col[k][1:0]));
    end
  end

  // Beat content: H columns, then the identity block, zero outside the skew window
  always_comb begin
    row_nxt  = '0;
    flag_nxt = '0;
    if (beat < END_BEAT) begin
      for (int k = 0; k < H_SIZE; k++) begin
        if (col[k] >= 6'sd0 && col[k] < 6'sd4) begin
          row_nxt[k] = rd_data[k];
        end else if (col[k] == $signed(6'(k + H_SIZE))) begin
          row_nxt[k].r = ONE_Q;
        end
      end
      flag_nxt[0] = (beat == 5'd0);
      flag_nxt[1] = (beat == 5'd2);
      flag_nxt[2] = (beat == 5'd4);
    end
  end

  // Load/send FSM with registered beat outputs; a stalled QRD freezes everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= LOAD;
      cnt    <= '0;
      beat   <= '0;
      busy_q <= 1'b0;
      row_q  <= '0;
      flag_q <= '0;
`ifdef PINGPONG_EN
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
`endif
    end else begin
      if (accept) cnt <= cnt + 4'd1;
`ifdef PINGPONG_EN
      if (fill_done) begin
        full[wr_bank] <= 1'b1;
        wr_bank       <= ~wr_bank;
      end
`endif
      case (state)
        LOAD: begin
          if (fill_done) begin
            state  <= SEND;
            beat   <= '0;
            busy_q <= 1'b1;
`ifdef PINGPONG_EN
            rd_bank <= wr_bank;
`endif
          end
        end
        SEND: begin
          if (bus.in_ready) begin
            row_q  <= row_nxt;
            flag_q <= flag_nxt;
`ifdef PINGPONG_EN
            if ((beat == LAST_BEAT || beat == END_BEAT) && other_full) begin
              // Chain straight into the other bank's matrix
              full[rd_bank] <= 1'b0;
              rd_bank       <= ~rd_bank;
              beat          <= '0;
            end else if (beat == END_BEAT) begin
              full[rd_bank] <= 1'b0;
              state         <= LOAD;
              busy_q        <= 1'b0;
              beat          <= '0;
            end else begin
              beat <= beat + 5'd1;
            end
`else
            if (beat == END_BEAT) begin
              state  <= LOAD;
              busy_q <= 1'b0;
              beat   <= '0;
            end else begin
              beat <= beat + 5'd1;
            end
`endif
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  assign bus.row_in_1_r = row_q[0].r;
  assign bus.row_in_1_i = row_q[0].i;
  assign bus.row_in_2_r = row_q[1].r;
  assign bus.row_in_2_i = row_q[1].i;
  assign bus.row_in_3_r = row_q[2].r;
  assign bus.row_in_3_i = row_q[2].i;
  assign bus.row_in_4_r = row_q[3].r;
  assign bus.row_in_4_i = row_q[3].i;
  assign bus.row_in_1_f = flag_q[0];
  assign bus.row_in_2_f = flag_q[1];
  assign bus.row_in_3_f = flag_q[2];
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_qrd_row_skewer.sv
// Scoreboard bench for qrd_row_skewer (single-bank build): matrices are
// loaded with random data and gaps, the QRD-side in_ready is randomised or
// patterned, and every emitted beat is checked against [H | I] skewed rows.
`timescale 1ns/1ps
module tb_qrd_row_skewer;
  import qrd_pkg::*;

  localparam int W = IN_WIDTH;

  typedef struct packed {
    logic [3:0][W-1:0] r;
    logic [3:0][W-1:0] i;
    logic [2:0]        f;
    logic              busy;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  qrd_row_skewer_if bus();

  qrd_row_skewer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  rec_t exp_q[$];
  rec_t last_rec = '0;
  int   pop_cnt = 0;
  int   mdl_cnt = 0;
  logic [W-1:0] mdl_r [16];
  logic [W-1:0] mdl_i [16];
  int   ir_mode = 0;
  int   ir_step = 0;
  logic chk_en = 1'b0;

  task automatic check_rec(input string name, input rec_t act, input rec_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %b want %b", name, $time, act, exp);
    end
  endtask

  function automatic rec_t dut_rec();
    rec_t x;
    x.r[0] = bus.row_in_1_r;  x.i[0] = bus.row_in_1_i;
    x.r[1] = bus.row_in_2_r;  x.i[1] = bus.row_in_2_i;
    x.r[2] = bus.row_in_3_r;  x.i[2] = bus.row_in_3_i;
    x.r[3] = bus.row_in_4_r;  x.i[3] = bus.row_in_4_i;
    x.f    = {bus.row_in_3_f, bus.row_in_2_f, bus.row_in_1_f};
    x.busy = bus.busy;
    return x;
  endfunction

  // Reference: build A = [H | I], row k at beat b shows A[k][b-k]
  function automatic void push_matrix();
    logic [W-1:0] ar [4][8];
    logic [W-1:0] ai [4][8];
    rec_t rc;
    for (int j = 0; j < 4; j++)
      for (int c = 0; c < 8; c++) begin
        if (c < 4) begin
          ar[j][c] = mdl_r[4*j + c];
          ai[j][c] = mdl_i[4*j + c];
        end else begin
          ar[j][c] = (c - 4 == j) ? W'(ONE_VAL) : '0;
          ai[j][c] = '0;
        end
      end
    for (int b = 0; b < NBEATS; b++) begin
      rc = '0;
      for (int k = 0; k < 4; k++) begin
        int c;
        c = b - k;
        if (c >= 0 && c < 8) begin
          rc.r[k] = ar[k][c];
          rc.i[k] = ai[k][c];
        end
      end
      rc.f    = {(b == 4), (b == 2), (b == 0)};
      rc.busy = 1'b1;
      exp_q.push_back(rc);
    end
    rc = '0;
    exp_q.push_back(rc);
  endfunction

  // Input side of the model: an element is taken whenever no matrix is pending
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_cnt = 0;
    end else if (bus.s_valid && exp_q.size() == 0) begin
      mdl_r[mdl_cnt] = bus.s_data_r;
      mdl_i[mdl_cnt] = bus.s_data_i;
      mdl_cnt++;
      if (mdl_cnt == 16) begin
        mdl_cnt = 0;
        push_matrix();
      end
    end
  end

  // Output monitor: pop on every advancing edge, otherwise check hold while stalled
  always @(posedge clk) begin
    rec_t e;
    if (rst_n && bus.busy) begin
      if (bus.in_ready) begin
        #1;
        if (rst_n) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL beat_unexpected @%0t: got %h want none", $time, dut_rec());
          end else begin
            e = exp_q.pop_front();
            check_rec("beat", dut_rec(), e);
            last_rec = e;
            pop_cnt++;
          end
        end
      end else begin
        #1;
        if (rst_n) begin
          e = last_rec;
          e.busy = 1'b1;
          check_rec("stall_hold", dut_rec(), e);
        end
      end
    end
  end

  // Handshake state follows the model: ready and not busy exactly when nothing is pending
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check_bit("s_ready", bus.s_ready, exp_q.size() == 0);
      check_bit("busy", bus.busy, exp_q.size() != 0);
    end
  end

  // QRD-side in_ready driver
  initial begin
    bus.in_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (ir_mode)
        0: bus.in_ready = 1'b1;
        1: bus.in_ready = ($urandom_range(0, 2) != 0);
        2: begin
          bus.in_ready = (ir_step % 4 == 0) || (ir_step % 4 == 3);
          ir_step++;
        end
        default: bus.in_ready = 1'b0;
      endcase
    end
  end

  task automatic load_matrix(input int kind, input int gap);
    int v;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      bus.s_valid = 1'b1;
      case (kind)
        0: begin
          v = 16 * (n / 4) + (n % 4);
          bus.s_data_r = W'(v);
          bus.s_data_i = W'(-v);
        end
        1: begin
          bus.s_data_r = W'($urandom);
          bus.s_data_i = W'($urandom);
        end
        default: begin
          case ($urandom_range(0, 3))
            0: bus.s_data_r = W'(-8192);
            1: bus.s_data_r = W'(8191);
            2: bus.s_data_r = '0;
            default: bus.s_data_r = '1;
          endcase
          bus.s_data_i = ($urandom_range(0, 1) != 0) ? W'(8191) : W'(-8192);
        end
      endcase
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        bus.s_valid = 1'b0;
      end
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        bus.s_valid = 1'b0;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL idle_timeout @%0t: pending=%0d want 0", $time, exp_q.size());
    exp_q.delete();
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_pops(input int target, input int max_cyc);
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (pop_cnt >= target) return;
    end
    total++;
    bad++;
    $display("FAIL pop_timeout @%0t: pops=%0d want %0d", $time, pop_cnt, target);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog @%0t: got timeout want finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bus.s_valid  = 1'b0;
    bus.s_data_r = '0;
    bus.s_data_i = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_rec("reset_outputs", dut_rec(), '0);
    check_bit("reset_s_ready", bus.s_ready, 1'b1);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Counting pattern, QRD always ready
    ir_mode = 0;
    load_matrix(0, 0);
    wait_idle(200);

    // Sparse input (one element every 3 cycles), in_ready pattern 1,0,0,1
    ir_mode = 2;
    load_matrix(1, 2);
    wait_idle(300);

    // s_valid held high with 0x1FFF while sending must not be consumed
    ir_mode = 1;
    load_matrix(1, 0);
    bus.s_valid  = 1'b1;
    bus.s_data_r = W'(14'h1FFF);
    bus.s_data_i = W'(14'h1FFF);
    wait_idle(300);
    load_matrix(2, 0);
    wait_idle(300);

    // Asynchronous reset in the middle of a matrix (after beat 5 is out)
    ir_mode = 0;
    base = pop_cnt;
    load_matrix(1, 0);
    wait_pops(base + 6, 100);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    last_rec = '0;
    #1;
    check_rec("async_reset_outputs", dut_rec(), '0);
    check_bit("async_reset_s_ready", bus.s_ready, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    load_matrix(0, 0);
    wait_idle(200);

    // Long QRD stall mid-matrix
    base = pop_cnt;
    load_matrix(1, 0);
    wait_pops(base + 3, 100);
    ir_mode = 3;
    repeat (40) @(negedge clk);
    ir_mode = 0;
    wait_idle(200);

    // Random matrices, random gaps and random in_ready
    ir_mode = 1;
    for (int m = 0; m < 4; m++) begin
      load_matrix(1 + (m % 2), $urandom_range(0, 2));
      wait_idle(400);
    end
    repeat (3) @(negedge clk);
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
